instr_fetch_unit: RTL and testbench

//  Producer side of the decoder's instruction interface: generates PCs, issues in-order instruction-memory reads,

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/instr_fetch_unit.sv | 165 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   fetch_entry_t  : {pc, instr} pair held in the fetch buffer
//   fetch_state_e  : fetch sequencer states
//   INSTR_NOP      : word presented to decode when nothing is valid
//   align_pc()     : clears the byte-offset bits of an address
package fetch_pkg;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } fetch_state_e;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush, used for the fetch buffer and the PC shadow queue.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   flush_i            empties the FIFO; overrides push/pop in the same cycle
//   push_i, data_i     write an entry (accepted when not full, or when full with a pop)
//   pop_i              drop the head entry (ignored when empty)
//   data_o             head entry (undefined when empty)
//   full_o, empty_o    occupancy flags
//   count_o            number of stored entries
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  // Storage needs no reset; reads of an empty FIFO are masked by the consumer.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: generates PCs, issues in-order imem reads, buffers returned words and
// presents {pc, instr} to decode over a valid/ready handshake. Redirects from execute flush all
// buffered state; responses still in flight at a redirect are counted and discarded on return.
// Ports:
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   imem_req_o, imem_addr_o          read request and word-aligned address (held until gnt)
//   imem_gnt_i                       request accepted
//   imem_rvalid_i, imem_rdata_i      in-order read response
//   redirect_i, redirect_pc_i        load new PC and flush
//   instr_valid_o, instr_ready_i     decode handshake
//   instr_o, pc_o                    head of the fetch buffer (NOP / 0 when invalid)
//   fetch_err_o                      misaligned redirect target seen
// Build option: FETCH_MISALIGN_TRAP_EN -- a misaligned redirect halts fetch and raises
// fetch_err_o until an aligned redirect; without it the low target bits are dropped.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        fetch_err_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e state_q;
  logic [31:0]  fetch_pc_q;
  logic         fetch_err_q;
  logic [CW-1:0] outstanding_q, outstanding_d, discard_q;

  logic [31:0]  redirect_tgt;
  logic         misaligned;
  logic         req_fire, resp_keep, resp_drop, issue_room;

  fetch_entry_t  push_entry, buf_head;
  logic          buf_empty, buf_full;
  logic [CW-1:0] buf_count;
  logic [31:0]   shadow_pc;
  logic          shadow_empty, shadow_full;
  logic [CW-1:0] shadow_count;
  logic          unused_ok;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redirect_tgt = redirect_pc_i;
  assign misaligned   = (redirect_pc_i[1:0] != 2'b00);
`else
  assign redirect_tgt = align_pc(redirect_pc_i);
  assign misaligned   = 1'b0;
`endif

  // Buffered plus in-flight words never exceed the buffer, so a push can never overflow.
  assign issue_room  = ({1'b0, buf_count} + {1'b0, outstanding_q}) < (CW + 1)'(FIFO_DEPTH);
  assign imem_req_o  = (state_q == RUN) && issue_room;
  assign imem_addr_o = fetch_pc_q;

  assign req_fire  = imem_req_o && imem_gnt_i;
  assign resp_drop = imem_rvalid_i && (discard_q != '0);
  assign resp_keep = imem_rvalid_i && (discard_q == '0) && !redirect_i;

  always_comb begin
    outstanding_d = outstanding_q;
    unique case ({req_fire, imem_rvalid_i})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      // Everything still in flight after this cycle belongs to the old stream.
      if (redirect_i) begin
        discard_q <= outstanding_d;
      end else if (resp_drop) begin
        discard_q <= discard_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= BOOT;
      fetch_pc_q  <= RESET_PC;
      fetch_err_q <= 1'b0;
    end else if (redirect_i) begin
      fetch_pc_q <= redirect_tgt;
      if (misaligned) begin
        state_q     <= HALT;
        fetch_err_q <= 1'b1;
      end else begin
        state_q     <= RUN;
        fetch_err_q <= 1'b0;
      end
    end else begin
      unique case (state_q)
        BOOT: state_q <= RUN;
        RUN:  if (req_fire) fetch_pc_q <= fetch_pc_q + 32'd4;
        HALT: state_q <= HALT;
        default: state_q <= BOOT;
      endcase
    end
  end

  // Constant zero unless the misalignment trap is built in.
  assign fetch_err_o = fetch_err_q;

  // PC of each live request, popped as its response is accepted.
  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_shadow (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (redirect_i),
    .push_i  (req_fire && !redirect_i),
    .data_i  (fetch_pc_q),
    .pop_i   (resp_keep),
    .data_o  (shadow_pc),
    .full_o  (shadow_full),
    .empty_o (shadow_empty),
    .count_o (shadow_count)
  );

  assign push_entry = '{pc: shadow_pc, instr: imem_rdata_i};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (redirect_i),
    .push_i  (resp_keep),
    .data_i  (push_entry),
    .pop_i   (instr_valid_o && instr_ready_i && !redirect_i),
    .data_o  (buf_head),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .count_o (buf_count)
  );

  assign instr_valid_o = !buf_empty;
  assign instr_o       = instr_valid_o ? buf_head.instr : INSTR_NOP;
  assign pc_o          = instr_valid_o ? buf_head.pc : 32'h0;

  assign unused_ok = ^{redirect_pc_i[1:0], buf_full, shadow_full, shadow_empty, shadow_count};

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: an in-order imem model with programmable grant and
// latency, and a scoreboard of expected {pc, instr} pushed at each grant and popped at each
// accepted output. Covers streaming, stalls, redirects (with in-flight and un-granted requests),
// misaligned targets, address wrap and asynchronous reset.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam int unsigned Depth   = 2;

  logic        clk, rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect, instr_valid, instr_ready, fetch_err;
  logic [31:0] redirect_pc, instr, pc;

  instr_fetch_unit #(
    .RESET_PC   (ResetPc),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (imem_gnt),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instr_o       (instr),
    .pc_o          (pc),
    .fetch_err_o   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] sb_pc[$], sb_instr[$];
  logic [31:0] resp_addr_q[$];
  int          resp_cyc_q[$];

  int          cycle_n, first_valid, resp_lat;
  logic        gnt_en, ready_en, redir, redir_prev, exp_err, exp_first_en;
  logic [31:0] redir_pc, exp_addr, exp_first_pc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cycle_n);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, update the model.
  task automatic cyc();
    imem_gnt    = gnt_en;
    instr_ready = ready_en;
    redirect    = redir;
    redirect_pc = redir_pc;
    if (resp_addr_q.size() > 0 && cycle_n >= resp_cyc_q[0] + resp_lat) begin
      imem_rvalid = 1'b1;
      imem_rdata  = ~resp_addr_q[0];
      resp_addr_q.delete(0);
      resp_cyc_q.delete(0);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    #1;
    check_eq("fetch_err", {31'b0, fetch_err}, {31'b0, exp_err});
    if (exp_err) check_eq("halt_req", {31'b0, imem_req}, 32'd0);
    if (redir_prev) check_eq("flush_valid", {31'b0, instr_valid}, 32'd0);
    if (instr_valid && first_valid < 0) first_valid = cycle_n;
    if (!instr_valid) begin
      check_eq("idle_nop", instr, INSTR_NOP);
    end else if (sb_pc.size() == 0) begin
      check_eq("unexpected_valid", {31'b0, instr_valid}, 32'd0);
    end else begin
      if (exp_first_en) begin
        check_eq("redir_first", pc, exp_first_pc);
        exp_first_en = 1'b0;
      end
      check_eq("pc", pc, sb_pc[0]);
      check_eq("instr", instr, sb_instr[0]);
      if (instr_ready && !redir) begin
        sb_pc.delete(0);
        sb_instr.delete(0);
      end
    end
    if (imem_req) begin
      check_eq("addr", imem_addr, exp_addr);
      if (imem_gnt) begin
        resp_addr_q.push_back(exp_addr);
        resp_cyc_q.push_back(cycle_n);
        if (!redir) begin
          sb_pc.push_back(exp_addr);
          sb_instr.push_back(~exp_addr);
        end
        exp_addr = exp_addr + 32'd4;
      end
    end
    if (redir) begin
      sb_pc.delete();
      sb_instr.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      exp_addr = redir_pc;
      exp_err  = (redir_pc[1:0] != 2'b00);
`else
      exp_addr = {redir_pc[31:2], 2'b00};
`endif
    end
    redir_prev = redir;
    redir      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cycle_n++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_redirect(input logic [31:0] tgt, input logic [31:0] first_pc);
    redir        = 1'b1;
    redir_pc     = tgt;
    cyc();
    exp_first_en = 1'b1;
    exp_first_pc = first_pc;
  endtask

  // Asserts reset away from a clock edge, checks reset outputs, releases on a falling edge.
  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("rst_req", {31'b0, imem_req}, 32'd0);
    check_eq("rst_addr", imem_addr, ResetPc);
    check_eq("rst_valid", {31'b0, instr_valid}, 32'd0);
    check_eq("rst_instr", instr, INSTR_NOP);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_err", {31'b0, fetch_err}, 32'd0);
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    sb_pc.delete(); sb_instr.delete(); resp_addr_q.delete(); resp_cyc_q.delete();
    exp_addr = ResetPc; exp_err = 1'b0; redir = 1'b0; redir_prev = 1'b0;
    exp_first_en = 1'b0; first_valid = -1;
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    cycle_n = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    gnt_en = 1'b1; ready_en = 1'b1; resp_lat = 1; redir_pc = 32'h0; cycle_n = 0;
    @(negedge clk);
    do_reset();

    // Streaming with 1-cycle imem: first word valid three cycles after reset release.
    run(20);
    check_eq("first_valid", first_valid, 32'd3);

    // Decode stall: buffer fills to Depth, request drops, head held.
    ready_en = 1'b0;
    run(5);
    check_eq("stall_req", {31'b0, imem_req}, 32'd0);
    check_eq("stall_valid", {31'b0, instr_valid}, 32'd1);
    check_eq("stall_buffered", sb_pc.size(), Depth);
    ready_en = 1'b1;
    run(10);

    // Redirect with two requests in flight on a slow imem.
    resp_lat = 3;
    for (int i = 0; i < 20 && resp_addr_q.size() < 2; i++) cyc();
    check_eq("two_outstanding", resp_addr_q.size(), 32'd2);
    do_redirect(32'h0000_0100, 32'h0000_0100);
    run(15);
    resp_lat = 1;

    // Un-granted request retargeted by a redirect.
    gnt_en = 1'b0;
    run(3);
    do_redirect(32'h0000_0040, 32'h0000_0040);
    check_eq("retarget", imem_addr, 32'h0000_0040);
    gnt_en = 1'b1;
    run(10);

    // Misaligned redirect target.
`ifdef FETCH_MISALIGN_TRAP_EN
    do_redirect(32'h0000_0102, 32'h0);
    exp_first_en = 1'b0;
    run(4);
    check_eq("trap_err", {31'b0, fetch_err}, 32'd1);
    do_redirect(32'h0000_0200, 32'h0000_0200);
    run(10);
`else
    do_redirect(32'h0000_0102, 32'h0000_0100);
    run(10);
`endif

    // Address wrap at the top of memory, then reset in the middle of a burst.
    do_redirect(32'hFFFF_FFF8, 32'hFFFF_FFF8);
    run(12);
    do_reset();
    run(10);

    gnt_en = 1'b0;
    for (int i = 0; i < 30 && sb_pc.size() > 0; i++) cyc();
    check_eq("drain", sb_pc.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
